sub_64_iter: RTL and testbench

//   Multi-cycle 64-bit subtractor for the ALU: computes diff = a - b - borrow_in

---
 rtl/sub64_pkg.sv | 13 +
 rtl/sub_slice16.sv | 14 +
 rtl/sub_64_iter.sv | 117 +++++++++++
 tb/tb_sub_64_iter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sub64_pkg.sv
// Shared constants and state encoding for the iterative 64-bit subtractor.
package sub64_pkg;
  localparam int WIDTH  = 64;
  localparam int SLICE  = 16;
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = $clog2(NSLICE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/sub_slice16.sv
// One 16-bit subtract slice: a + ~b + cin, carry out is the inverted borrow.
module sub_slice16
  import sub64_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);
  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, cin};
  end
endmodule

// File: rtl/sub_64_iter.sv
// Multi-cycle 64-bit subtractor, one slice per clock, LSB slice first.
// Handshake: a transfer happens on a rising edge where valid && ready are both high;
// in_ready is high only in IDLE, out_valid only in DONE, and results hold until taken.
module sub_64_iter
  import sub64_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state
);
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic               borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [SLICE-1:0]   slice_s;
  logic               slice_c;
  logic               last_slice;

  sub_slice16 u_slice (
    .a    (a_q[idx_q*SLICE +: SLICE]),
    .b    (b_q[idx_q*SLICE +: SLICE]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  assign last_slice = (idx_q == IDX_W'(NSLICE-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_RUN;
      S_RUN:   if (last_slice) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ~borrow_in;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        diff_d[idx_q*SLICE +: SLICE] = slice_s;
        carry_d = slice_c;
        idx_d   = idx_q + IDX_W'(1);
        // Flags are taken from the fully assembled result on the final slice edge.
        if (last_slice) begin
          borrow_d = ~slice_c;
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d   = ~|diff_d;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == S_IDLE);
    out_valid  = (state_q == S_DONE);
    diff       = diff_q;
    borrow_out = borrow_q;
    ovf        = ovf_q;
    zero       = zero_q;
    dbg_state  = state_q;
  end
endmodule

// File: tb/tb_sub_64_iter.sv
// Bench for sub_64_iter: directed corner cases plus random ops against a wide-arithmetic model.
module tb_sub_64_iter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        borrow_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] diff;
  logic        borrow_out, ovf, zero;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];
  logic [2:0]  flag_q[$];

  sub_64_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out),
    .ovf(ovf), .zero(zero), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference: wide integer arithmetic, both unsigned and signed views.
  task automatic model_push(input logic [63:0] ma, input logic [63:0] mb, input logic mbin);
    logic [65:0] u;
    logic [65:0] s;
    logic [63:0] d;
    logic        bo, ov, z;
    u  = {2'b00, ma} - {2'b00, mb} - {65'd0, mbin};
    s  = {{2{ma[63]}}, ma} - {{2{mb[63]}}, mb} - {65'd0, mbin};
    d  = u[63:0];
    bo = u[65];
    ov = (s[65:63] != 3'b000) && (s[65:63] != 3'b111);
    z  = (d == 64'd0);
    exp_q.push_back(d);
    flag_q.push_back({bo, ov, z});
  endtask

  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic tbin,
                        input int hold);
    int cyc;
    logic [63:0] ed, held_d;
    logic [2:0]  ef, held_f;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check_val("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; a = ta; b = tb_v; borrow_in = tbin;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; borrow_in = $urandom_range(0, 1);
    model_push(ta, tb_v, tbin);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check_val("latency", cyc, 4);
    check_val("in_ready_busy", {63'd0, in_ready}, 64'd0);
    held_d = diff;
    held_f = {borrow_out, ovf, zero};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_val("hold_valid", {63'd0, out_valid}, 64'd1);
      check_val("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check_val("hold_diff", diff, held_d);
      check_val("hold_flags", {61'd0, borrow_out, ovf, zero}, {61'd0, held_f});
    end
    ed = exp_q.pop_front();
    ef = flag_q.pop_front();
    check_val("diff", diff, ed);
    check_val("flags_bo_ov_z", {61'd0, borrow_out, ovf, zero}, {61'd0, ef});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("out_valid_drop", {63'd0, out_valid}, 64'd0);
    check_val("in_ready_after", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_diff", diff, 64'd0);
    check_val("rst_flags", {61'd0, borrow_out, ovf, zero}, 64'd0);
    check_val("rst_state", {62'd0, dbg_state}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(64'h10, 64'h1, 1'b0, 0);
    run_op(64'h0, 64'h1, 1'b0, 0);
    run_op(64'h0000_0001_0000_0000, 64'h1, 1'b0, 0);
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1);
    run_op(64'h1234, 64'h1234, 1'b0, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
    run_op(64'h0, 64'h0, 1'b1, 0);
    run_op(64'hDEAD_BEEF_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 3);

    // Abort mid-RUN at slice index 2.
    in_valid = 1'b1; a = 64'hFFFF_0000_FFFF_0000; b = 64'h1111; borrow_in = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check_val("abort_diff", diff, 64'd0);
    check_val("abort_flags", {61'd0, borrow_out, ovf, zero}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_val("abort_no_valid", {63'd0, out_valid}, 64'd0);
    end
    run_op(64'h5, 64'h3, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: rb = ra;
        1: rb = ra + 64'(1);
        2: ra = {ra[63], 15'h7FFF, 48'hFFFF_FFFF_FFFF};
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
